// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared size codes, FSM states and WB_control bit positions
package load_store_unit_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int WB_REGWRITE  = 3;
  localparam int WB_MEMTOREG  = 2;
  localparam int WB_REGSRC_HI = 1;
  localparam int WB_REGSRC_LO = 0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  // Illegal size codes count as misaligned so they take the same no-bus path.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_H || f3 == F3_HU) ? a[0] :
           (f3 == F3_W) ? |a :
           (f3 == F3_B || f3 == F3_BU) ? 1'b0 : 1'b1;
  endfunction
endpackage

// File: rtl/load_store_unit_load_formatter.sv
// load_formatter: extracts and sign/zero-extends the loaded byte/half/word
// Ports: funct3 size code, addr_lo byte offset, rdata bus word, data formatted result.
module load_formatter
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  assign shifted = rdata >> {addr_lo, 3'b000};
  assign b = shifted[7:0];
  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_BU ? {24'b0, b} :
                funct3 == F3_HU ? {16'b0, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store bus master with stall, misalign and ack timeout
// Ports: CLK/RESET (async active-low); pipeline valid_i, MemRead_i, MemWrite_i, funct3_i,
// ALUResult_i, WriteData_i; bus mem_req/we/addr/wdata/wstrb, mem_ack/rdata;
// results ReadData, stall, misalign, bus_err.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);
  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] load_data;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;
  logic        access, bad, accept, timeout;
  logic [1:0]  sz;
  logic [1:0]  a;
  assign sz = funct3_i[1:0];
  assign a = ALUResult_i[1:0];
  assign access = valid_i & (MemRead_i | MemWrite_i);
  assign bad = misaligned(funct3_i, a);
  assign accept = state == IDLE && access && !bad;
  // RESET gates stall so a held instruction cannot freeze the pipe during reset.
  assign stall = RESET & (accept | (state == BUSY));
  assign timeout = ACK_TIMEOUT != 0 && cnt == 32'(ACK_TIMEOUT - 1);
  assign wdata_n = sz == 2'd0 ? {4{WriteData_i[7:0]}} :
                   sz == 2'd1 ? {2{WriteData_i[15:0]}} : WriteData_i;
  assign wstrb_n = sz == 2'd0 ? 4'b0001 << a :
                   sz == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  load_formatter u_fmt (
    .funct3 (f3_q),
    .addr_lo(lo_q),
    .rdata  (mem_rdata),
    .data   (load_data)
  );
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      ReadData  <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (access && bad) misalign <= 1'b1;
          else if (access) begin
            state     <= BUSY;
            cnt       <= '0;
            f3_q      <= funct3_i;
            lo_q      <= a;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_i;
            mem_addr  <= {ALUResult_i[31:2], 2'b00};
            mem_wdata <= wdata_n;
            mem_wstrb <= MemWrite_i ? wstrb_n : 4'b0000;
          end
        end
        BUSY: begin
          // ack is checked first so a same-cycle ack beats the timeout
          if (mem_ack) begin
            if (!mem_we) ReadData <= load_data;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (timeout) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else if (ACK_TIMEOUT != 0) cnt <= cnt + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks against a behavioural access model
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        valid_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] ALUResult_i = '0, WriteData_i = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ReadData;
  logic        stall, misalign, bus_err;
  int checks = 0, errors = 0;
  logic [31:0] exp_rd = '0;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .valid_i(valid_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUResult_i(ALUResult_i),
    .WriteData_i(WriteData_i), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadData(ReadData),
    .stall(stall), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result from the architectural rules: pick the addressed byte/half, then extend.
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned sh, range;
    logic [31:0] v;
    if (f3 == 3'd2) return rd;
    range = (f3 % 4 == 1) ? 65536 : 256;
    sh = (f3 % 4 == 1) ? ((a % 4 >= 2) ? 16 : 0) : 8 * (a % 4);
    v = (rd >> sh) % range;
    if (f3 < 4 && v >= range / 2) v = v - range;
    return v;
  endfunction

  // One instruction in MEM; ack_at = BUSY cycle (1-based) carrying mem_ack, 0 = never.
  task automatic run(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    logic mis, to;
    logic [31:0] ew;
    logic [3:0] es;
    int sz;
    sz = f3 % 4;
    mis = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    ew = sz == 0 ? (wd % 256) * 32'h01010101 : sz == 1 ? (wd % 65536) * 32'h00010001 : wd;
    es = ld ? 4'd0 : sz == 0 ? 4'(1 << (a % 4)) : sz == 1 ? 4'(3 << (a % 4)) : 4'd15;
    @(posedge CLK); #1;
    valid_i = 1; MemRead_i = ld; MemWrite_i = !ld; funct3_i = f3; ALUResult_i = a; WriteData_i = wd;
    #3 check("stall_accept", 32'(stall), 32'(!mis));
    if (mis) begin
      @(posedge CLK); #1;
      valid_i = 0;
      check("misalign_pulse", 32'(misalign), 1);
      check("misalign_no_req", 32'(mem_req), 0);
      #1 check("misalign_stall", 32'(stall), 0);
      @(posedge CLK); #1;
      check("misalign_clear", 32'(misalign), 0);
      return;
    end
    to = 1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      check("busy_req", 32'(mem_req), 1);
      check("busy_stall", 32'(stall), 1);
      check("busy_addr", mem_addr, a & ~32'd3);
      check("busy_we", 32'(mem_we), 32'(!ld));
      check("busy_wstrb", 32'(mem_wstrb), 32'(es));
      if (!ld) check("busy_wdata", mem_wdata, ew);
      mem_ack = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : $urandom;
      if (k == ack_at) begin
        to = 0;
        if (ld) exp_rd = fmt(f3, a, rd);
        break;
      end
    end
    @(posedge CLK); #1;
    mem_ack = 0;
    check("done_req", 32'(mem_req), 0);
    check("done_stall", 32'(stall), 0);
    check("done_bus_err", 32'(bus_err), 32'(to));
    check("done_readdata", ReadData, exp_rd);
    @(posedge CLK); #1;
    valid_i = 0;
    check("idle_bus_err", 32'(bus_err), 0);
    check("idle_no_reaccept", 32'(mem_req), 0);
    #1 check("idle_stall", 32'(stall), 0);
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
    #12;
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", 32'(mem_wstrb), 0);
    check("rst_readdata", ReadData, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    RESET = 1;
    run(1, 3'd2, 32'h100, 0, 32'hDEADBEEF, 2);
    check("lw_value", ReadData, 32'hDEADBEEF);
    run(1, 3'd0, 32'h103, 0, 32'h80FF1234, 1);
    check("lb_value", ReadData, 32'hFFFFFF80);
    run(1, 3'd4, 32'h103, 0, 32'h80FF1234, 3);
    check("lbu_value", ReadData, 32'h00000080);
    run(1, 3'd5, 32'h102, 0, 32'h80FF1234, 4);
    check("lhu_value", ReadData, 32'h000080FF);
    run(0, 3'd0, 32'h201, 32'h000000A5, 0, 1);
    run(0, 3'd1, 32'h202, 32'h00001234, 0, 2);
    run(1, 3'd2, 32'h102, 0, 0, 1);
    run(1, 3'd3, 32'h100, 0, 0, 1);
    run(1, 3'd2, 32'h140, 0, 32'h11112222, 0);
    check("timeout_keeps_readdata", ReadData, 32'h000080FF);
    @(posedge CLK); #1;
    mem_ack = 1; mem_rdata = 32'h55555555;
    @(posedge CLK); #1;
    mem_ack = 0;
    check("stray_ack_readdata", ReadData, exp_rd);
    check("stray_ack_req", 32'(mem_req), 0);
    for (int i = 0; i < 40; i++)
      run(1'($urandom), f3s[$urandom_range(0, 7)], $urandom, $urandom, $urandom, $urandom_range(0, 5));
    @(posedge CLK); #1;
    valid_i = 1; MemRead_i = 1; MemWrite_i = 0; funct3_i = 3'd2; ALUResult_i = 32'h300;
    @(posedge CLK); #1;
    check("pre_reset_req", 32'(mem_req), 1);
    #1 RESET = 0;
    #1;
    check("async_rst_req", 32'(mem_req), 0);
    check("async_rst_stall", 32'(stall), 0);
    check("async_rst_addr", mem_addr, 0);
    #1 RESET = 1;
    valid_i = 0;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    mem_ack = 0;
    exp_rd = 0;
    check("late_ack_readdata", ReadData, exp_rd);
    check("late_ack_req", 32'(mem_req), 0);
    check("late_ack_bus_err", 32'(bus_err), 0);
    check("late_ack_stall", 32'(stall), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
